// File: rtl/moving_avg_filter.sv
// Boxcar moving-average stage: mean of the last 2**WIN_LOG2 accepted samples,
// kept as a circular register buffer plus a running sum (one add, one subtract per sample).
module moving_avg_filter #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    sample_valid,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic signed [WIDTH-1:0] avg_out,
  output logic                    avg_valid,
  output logic                    primed
);

  localparam int N     = 1 << WIN_LOG2;
  localparam int SUM_W = WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] FILL_MAX = {1'b1, {WIN_LOG2{1'b0}}};

  logic signed [WIDTH-1:0] buf_mem [N];
  logic [WIN_LOG2-1:0]     wr_ptr;
  logic signed [SUM_W-1:0] sum;
  logic [WIN_LOG2:0]       fill_cnt;

  logic                    accept;
  logic signed [SUM_W-1:0] sum_next;
  logic [WIN_LOG2:0]       fill_next;

  assign accept = sample_valid && !flush;

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    sum_next  = sum;
    fill_next = fill_cnt;
    if (accept) begin
      sum_next = sum
               + {{WIN_LOG2{sample_in[WIDTH-1]}}, sample_in}
               - {{WIN_LOG2{buf_mem[wr_ptr][WIDTH-1]}}, buf_mem[wr_ptr]};
      fill_next = (fill_cnt == FILL_MAX) ? FILL_MAX : fill_cnt + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the buffer is cleared on reset/flush because the ramp-up average
  // depends on zero-filled slots being subtracted, not on X.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) buf_mem[i] <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) buf_mem[i] <= '0;
      wr_ptr    <= '0;
      sum       <= '0;
      fill_cnt  <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
      primed    <= 1'b0;
    end else if (accept) begin
      buf_mem[wr_ptr] <= sample_in;
      wr_ptr    <= wr_ptr + 1'b1;
      sum       <= sum_next;
      fill_cnt  <= fill_next;
      // Dropping the low WIN_LOG2 bits of a signed sum is floor division by N.
      avg_out   <= sum_next[SUM_W-1:WIN_LOG2];
      avg_valid <= 1'b1;
      primed    <= (fill_next == FILL_MAX);
    end else begin
      avg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_avg_filter.sv
// Self-checking bench for moving_avg_filter: directed vector table, async reset
// sequence, and randomized traffic against a window-history reference model.
module tb_moving_avg_filter;

  localparam int WIDTH    = 16;
  localparam int WIN_LOG2 = 4;
  localparam int N        = 1 << WIN_LOG2;

  logic                    clk;
  logic                    rst;
  logic                    flush;
  logic                    sample_valid;
  logic signed [WIDTH-1:0] sample_in;
  logic signed [WIDTH-1:0] avg_out;
  logic                    avg_valid;
  logic                    primed;

  moving_avg_filter #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .avg_out      (avg_out),
    .avg_valid    (avg_valid),
    .primed       (primed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [15:0] data;
    logic [15:0] exp_avg;
    logic        exp_valid;
    logic        exp_primed;
  } vec_t;

  vec_t vecs[$];

  int passes = 0;
  int total  = 0;

  // Reference model: history of accepted samples, mean over the last N.
  int   hist[$];
  int   m_cnt;
  int   m_avg;
  logic m_valid;
  logic m_primed;

  function automatic int fdiv(input int s);
    int q;
    q = s / N;
    if ((s % N) != 0 && s < 0) q--;
    return q;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    hist.delete();
    m_cnt    = 0;
    m_avg    = 0;
    m_valid  = 1'b0;
    m_primed = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic f, input logic [15:0] d);
    int s;
    if (f) begin
      model_reset();
    end else if (v) begin
      hist.push_back(int'(signed'(d)));
      if (hist.size() > N) void'(hist.pop_front());
      m_cnt++;
      s = 0;
      foreach (hist[i]) s += hist[i];
      m_avg   = fdiv(s);
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    m_primed = (m_cnt >= N);
  endtask

  // Apply one cycle of stimulus and advance the model; outputs are sampled 1 after the edge.
  task automatic drive(input logic v, input logic f, input logic [15:0] d);
    sample_valid = v;
    flush        = f;
    sample_in    = d;
    @(posedge clk);
    #1;
    model_step(v, f, d);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".avg_out"},   avg_out,   m_avg[15:0]);
    check({tag, ".avg_valid"}, avg_valid, m_valid);
    check({tag, ".primed"},    primed,    m_primed);
  endtask

  task automatic add(input logic v, input logic f, input logic [15:0] d,
                     input int ea, input logic ev, input logic ep);
    vec_t t;
    t.valid = v; t.flush = f; t.data = d;
    t.exp_avg = ea[15:0]; t.exp_valid = ev; t.exp_primed = ep;
    vecs.push_back(t);
  endtask

  initial begin
    // Directed table: expectations written from closed-form window sums.
    for (int k = 1; k <= 20; k++) add(1, 0, 16'h0010, (k < 16) ? k : 16, 1, k >= 16);
    add(1, 1, 16'h1234, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(1, 0, 16'h0100, 16 * k, 1, k == 16);
    for (int k = 1; k <= 16; k++) add(1, 0, 16'h0000, 256 - 16 * k, 1, 1);
    add(0, 1, 16'h0000, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(1, 0, 16'hFFFF, -1, 1, k == 16);
    add(1, 0, 16'h0000, -1, 1, 1);
    add(0, 1, 16'h0000, 0, 0, 0);
    for (int k = 1; k <= 16; k++) add(1, 0, 16'h8000, fdiv(-32768 * k), 1, k == 16);
    for (int j = 1; j <= 16; j++)
      add(1, 0, 16'h7FFF, fdiv(-32768 * (16 - j) + 32767 * j), 1, 1);
    add(0, 1, 16'h0000, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      add(1, 0, 16'h0020, 2 * k, 1, 0);
      add(0, 0, 16'h0000, 2 * k, 0, 0);
      add(0, 0, 16'h0000, 2 * k, 0, 0);
    end
    add(1, 1, 16'h0020, 0, 0, 0);
    add(1, 0, 16'h0010, 1, 1, 0);

    rst = 1'b0; flush = 1'b0; sample_valid = 1'b0; sample_in = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.avg_out",   avg_out,   16'h0000);
    check("reset.avg_valid", avg_valid, 1'b0);
    check("reset.primed",    primed,    1'b0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].flush, vecs[i].data);
      check($sformatf("vec%0d.avg_out", i),   avg_out,   vecs[i].exp_avg);
      check($sformatf("vec%0d.avg_valid", i), avg_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d.primed", i),    primed,    vecs[i].exp_primed);
    end

    // Async reset mid-stream while primed: clears between edges, then restarts at sample #1.
    drive(0, 1, 16'h0000);
    for (int k = 0; k < N; k++) drive(1, 0, 16'h0010);
    check("pre_areset.primed",  primed,  1'b1);
    check("pre_areset.avg_out", avg_out, 16'h0010);
    sample_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("areset.avg_out", avg_out, 16'h0000);
    check("areset.primed",  primed,  1'b0);
    #2 rst = 1'b1;
    model_reset();
    drive(1, 0, 16'h0010);
    check("post_areset.avg_out",   avg_out,   16'h0001);
    check("post_areset.avg_valid", avg_valid, 1'b1);
    check("post_areset.primed",    primed,    1'b0);

    // Randomized traffic with occasional flushes and extreme values.
    for (int c = 0; c < 400; c++) begin
      logic        v, f;
      logic [15:0] d;
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 7))
        0:       d = 16'h8000;
        1:       d = 16'h7FFF;
        default: d = 16'($urandom);
      endcase
      drive(v, f, d);
      check_model($sformatf("rand%0d", c));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
